// File: rtl/kb_frame_rx.sv
// PS/2 device-to-host frame receiver: start, 8 data LSB first, odd parity, stop.
// Ports: clk, i_sclr (sync reset), i_edge_en (sample strobe), i_ps2_data (raw line),
//        o_data (last good byte), o_valid / o_parity_err / o_frame_err / o_timeout (1-cycle pulses).
module kb_frame_rx #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       i_sclr,
  input  logic       i_edge_en,
  input  logic       i_ps2_data,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      sync_q;
  logic [7:0]      shreg_q, shreg_d;
  logic [2:0]      bcnt_q, bcnt_d;
  logic [CW-1:0]   wd_q, wd_d;
  logic            par_q, par_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            tout_q, tout_d;
  logic            sd;
  logic            wd_term;

  assign sd      = sync_q[1];
  assign wd_term = (wd_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (i_sclr) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      wd_q    <= '0;
      par_q   <= 1'b0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], i_ps2_data};
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      wd_q    <= wd_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      tout_q  <= tout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    tout_d  = 1'b0;

    // Watchdog only runs while a frame is in progress
    if (state_q == S_IDLE || i_edge_en) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + CW'(1);
    end

    if (i_edge_en) begin
      unique case (state_q)
        S_IDLE: begin
          if (!sd) begin
            state_d = S_DATA;
            bcnt_d  = '0;
          end
        end
        S_DATA: begin
          shreg_d = {sd, shreg_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            state_d = S_PARITY;
          end
        end
        S_PARITY: begin
          par_d   = sd;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (!sd) begin
            ferr_d = 1'b1;
          end else if (^{shreg_q, par_q} != 1'b1) begin
            perr_d = 1'b1;
          end else begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE && wd_term) begin
      state_d = S_IDLE;
      wd_d    = '0;
      tout_d  = 1'b1;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_timeout    = tout_q;

endmodule

// File: tb/tb_kb_frame_rx.sv
// Self-checking bench for kb_frame_rx: directed plan plus random frames
// checked against a frame-level model (parity via population count).
module tb_kb_frame_rx;

  logic       clk = 1'b0;
  logic       i_sclr = 1'b1;
  logic       i_edge_en = 1'b0;
  logic       i_ps2_data = 1'b1;
  logic [7:0] o_data;
  logic       o_valid, o_parity_err, o_frame_err, o_timeout;

  int checks = 0;
  int errors = 0;
  int n_valid = 0, n_perr = 0, n_ferr = 0, n_tout = 0;
  logic [7:0] model_data = 8'h00;

  kb_frame_rx #(.TIMEOUT_CYCLES(1000)) dut (
    .clk          (clk),
    .i_sclr       (i_sclr),
    .i_edge_en    (i_edge_en),
    .i_ps2_data   (i_ps2_data),
    .o_data       (o_data),
    .o_valid      (o_valid),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_timeout    (o_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_valid)      n_valid++;
    if (o_parity_err) n_perr++;
    if (o_frame_err)  n_ferr++;
    if (o_timeout)    n_tout++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    i_ps2_data = b;
    repeat (gap) @(posedge clk);
    #1 i_edge_en = 1'b1;
    @(posedge clk);
    #1 i_edge_en = 1'b0;
  endtask

  // Sends a whole frame and checks pulse counts and o_data against the model.
  task automatic frame(input string tag, input logic [7:0] d,
                       input logic par, input logic stp);
    int v0, p0, f0, t0;
    int ev, ep, ef;
    int gap;
    v0 = n_valid; p0 = n_perr; f0 = n_ferr; t0 = n_tout;
    gap = $urandom_range(3, 8);
    send_bit(1'b0, gap);
    for (int i = 0; i < 8; i++) send_bit(d[i], gap);
    send_bit(par, gap);
    send_bit(stp, gap);
    ev = 0; ep = 0; ef = 0;
    if (!stp) ef = 1;
    else if (($countones(d) + par) % 2 != 1) ep = 1;
    else begin
      ev = 1;
      model_data = d;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, ".valid"}, n_valid - v0, ev);
    chk({tag, ".perr"},  n_perr - p0,  ep);
    chk({tag, ".ferr"},  n_ferr - f0,  ef);
    chk({tag, ".tout"},  n_tout - t0,  0);
    chk({tag, ".data"},  o_data, model_data);
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  initial begin
    int v0, p0, f0, t0;
    logic [7:0] rd;
    int kind;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.data", o_data, 8'h00);
    chk("rst.pulses", {o_valid, o_parity_err, o_frame_err, o_timeout}, 0);
    #1 i_sclr = 1'b0;
    repeat (2) @(posedge clk);

    frame("good1c", 8'h1C, 1'b0, 1'b1);
    frame("b2b_f0", 8'hF0, 1'b1, 1'b1);
    frame("b2b_1c", 8'h1C, 1'b0, 1'b1);
    frame("perr",   8'h1C, 1'b1, 1'b1);
    frame("ferr",   8'h1C, 1'b0, 1'b0);

    // Stall mid-frame: start plus 4 data bits then silence
    v0 = n_valid; p0 = n_perr; f0 = n_ferr; t0 = n_tout;
    send_bit(1'b0, 4);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 4);
    i_ps2_data = 1'b1;
    repeat (1100) @(posedge clk);
    @(negedge clk);
    chk("tout.cnt", n_tout - t0, 1);
    chk("tout.other", (n_valid - v0) + (n_perr - p0) + (n_ferr - f0), 0);
    chk("tout.data", o_data, model_data);
    frame("after_tout", 8'h5A, 1'b1, 1'b1);

    // Spurious edges with the line high in idle
    v0 = n_valid; p0 = n_perr; f0 = n_ferr; t0 = n_tout;
    for (int i = 0; i < 3; i++) send_bit(1'b1, 4);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("spur.pulses",
        (n_valid - v0) + (n_perr - p0) + (n_ferr - f0) + (n_tout - t0), 0);
    frame("after_spur", 8'h1C, 1'b0, 1'b1);

    // Reset in the middle of a frame
    v0 = n_valid; p0 = n_perr; f0 = n_ferr; t0 = n_tout;
    send_bit(1'b0, 4);
    for (int i = 0; i < 5; i++) send_bit(i[0], 4);
    #1 i_sclr = 1'b1;
    i_ps2_data = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_data = 8'h00;
    chk("sclr.data", o_data, 8'h00);
    chk("sclr.outs", {o_valid, o_parity_err, o_frame_err, o_timeout}, 0);
    #1 i_sclr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sclr.pulses",
        (n_valid - v0) + (n_perr - p0) + (n_ferr - f0) + (n_tout - t0), 0);
    frame("after_sclr", 8'h1C, 1'b0, 1'b1);

    // Random frames: good, bad parity, or bad stop
    for (int n = 0; n < 24; n++) begin
      rd = 8'($urandom);
      kind = $urandom_range(0, 3);
      if (kind == 0) frame("rnd_perr", rd, ~odd_par(rd), 1'b1);
      else if (kind == 1) frame("rnd_ferr", rd, 1'($urandom), 1'b0);
      else frame("rnd_good", rd, odd_par(rd), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
